// File: rtl/multi_cycle_controller_if.sv
// Control bundle between the multi-cycle RV32I controller and its datapath.
// The controller is the master: it samples IR decode fields and the ALU zero flag and drives the selects/strobes.
interface multi_cycle_controller_if;
    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       zero;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_function;
    logic [2:0] imm_src;
    logic       illegal;
    logic [3:0] state;   // debug view of the FSM state register

    modport master (
        input  opcode, f3, f7, zero,
        output pc_write, adr_src, mem_write, ir_write, reg_write,
        output result_src, alu_src_a, alu_src_b, alu_function, imm_src,
        output illegal, state
    );

    modport slave (
        output opcode, f3, f7, zero,
        input  pc_write, adr_src, mem_write, ir_write, reg_write,
        input  result_src, alu_src_a, alu_src_b, alu_function, imm_src,
        input  illegal, state
    );
endinterface

// File: rtl/multi_cycle_controller.sv
// One-state-per-clock FSM for the multi-cycle RV32I core: decodes IR fields and drives datapath selects and strobes.
// No handshake: memory is single-cycle, so every state lasts exactly one clock.
module multi_cycle_controller (
    input  logic                       clk,
    input  logic                       reset,
    multi_cycle_controller_if.master   bus
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] FN_ADD  = 3'b000;
    localparam logic [2:0] FN_SUB  = 3'b001;
    localparam logic [2:0] FN_AND  = 3'b010;
    localparam logic [2:0] FN_OR   = 3'b011;
    localparam logic [2:0] FN_XOR  = 3'b100;
    localparam logic [2:0] FN_SLT  = 3'b101;
    localparam logic [2:0] FN_SLTU = 3'b110;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADR   = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXEC_R    = 4'd6,
        EXEC_I    = 4'd7,
        ALU_WB    = 4'd8,
        BRANCH    = 4'd9,
        JALR_ADR  = 4'd10,
        JUMP      = 4'd11,
        LUI       = 4'd12
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_function;
    } ctrl_t;

    function automatic logic [2:0] alu_op(input logic [2:0] f3, input logic sub);
        logic [2:0] fn;
        case (f3)
            3'b000:  fn = sub ? FN_SUB : FN_ADD;
            3'b111:  fn = FN_AND;
            3'b110:  fn = FN_OR;
            3'b100:  fn = FN_XOR;
            3'b010:  fn = FN_SLT;
            3'b011:  fn = FN_SLTU;
            default: fn = FN_ADD;
        endcase
        return fn;
    endfunction

    function automatic logic is_legal(input logic [6:0] op, input logic [2:0] f3, input logic f7b5);
        logic alu_f3_ok;
        logic ok;
        alu_f3_ok = (f3 != 3'b001) && (f3 != 3'b101);
        case (op)
            OP_R:              ok = alu_f3_ok && (!f7b5 || f3 == 3'b000);
            OP_I:              ok = alu_f3_ok;
            OP_LOAD, OP_STORE: ok = (f3 == 3'b010);
            OP_BRANCH:         ok = f3 inside {3'b000, 3'b001, 3'b100, 3'b101};
            OP_JAL, OP_LUI:    ok = 1'b1;
            OP_JALR:           ok = (f3 == 3'b000);
            default:           ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Moore outputs of a state; only the EXEC/BRANCH function depends on IR, which is stable by then.
    function automatic ctrl_t state_ctrl(input state_e s, input logic [2:0] f3, input logic f7b5);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH:     begin c.ir_write = 1'b1; c.pc_write = 1'b1;
                             c.alu_src_b = 2'b10; c.result_src = 2'b10; end
            DECODE:    begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
            MEM_ADR:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
            MEM_READ:  c.adr_src = 1'b1;
            MEM_WB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
            MEM_WRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
            EXEC_R:    begin c.alu_src_a = 2'b10; c.alu_function = alu_op(f3, f7b5); end
            EXEC_I:    begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01;
                             c.alu_function = alu_op(f3, 1'b0); end
            ALU_WB:    c.reg_write = 1'b1;
            BRANCH:    begin c.alu_src_a = 2'b10; c.alu_function = f3[2] ? FN_SLT : FN_SUB; end
            JALR_ADR:  begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
            JUMP:      begin c.pc_write = 1'b1; c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; end
            LUI:       begin c.result_src = 2'b11; c.reg_write = 1'b1; end
            default:   c = '0;
        endcase
        return c;
    endfunction

    state_e state_q, state_d;
    ctrl_t  ctrl_q;
    logic   legal;
    logic   taken;
    logic   unused_f7;

    assign unused_f7 = ^{bus.f7[6], bus.f7[4:0]};
    assign legal     = is_legal(bus.opcode, bus.f3, bus.f7[5]);

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:    state_d = DECODE;
            DECODE: begin
                if (legal) begin
                    case (bus.opcode)
                        OP_LOAD, OP_STORE: state_d = MEM_ADR;
                        OP_R:              state_d = EXEC_R;
                        OP_I:              state_d = EXEC_I;
                        OP_BRANCH:         state_d = BRANCH;
                        OP_JAL:            state_d = JUMP;
                        OP_JALR:           state_d = JALR_ADR;
                        OP_LUI:            state_d = LUI;
                        default:           state_d = FETCH;
                    endcase
                end
            end
            MEM_ADR:  state_d = (bus.opcode == OP_STORE) ? MEM_WRITE : MEM_READ;
            MEM_READ: state_d = MEM_WB;
            EXEC_R:   state_d = ALU_WB;
            EXEC_I:   state_d = ALU_WB;
            JALR_ADR: state_d = JUMP;
            JUMP:     state_d = ALU_WB;
            default:  state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
            ctrl_q  <= state_ctrl(FETCH, 3'b000, 1'b0);
        end else begin
            state_q <= state_d;
            ctrl_q  <= state_ctrl(state_d, bus.f3, bus.f7[5]);
        end
    end

    // beq/bge take on zero, bne/blt on !zero; f3[0] xor f3[2] selects the inverted sense.
    assign taken = (state_q == BRANCH) && (bus.zero ^ (bus.f3[0] ^ bus.f3[2]));

    // Strobes are gated by reset so an aborted instruction never writes; illegal decodes the freshly loaded IR.
    assign bus.pc_write     = reset & (ctrl_q.pc_write | taken);
    assign bus.ir_write     = reset & ctrl_q.ir_write;
    assign bus.mem_write    = reset & ctrl_q.mem_write;
    assign bus.reg_write    = reset & ctrl_q.reg_write;
    assign bus.illegal      = reset & (state_q == DECODE) & ~legal;
    assign bus.adr_src      = ctrl_q.adr_src;
    assign bus.result_src   = ctrl_q.result_src;
    assign bus.alu_src_a    = ctrl_q.alu_src_a;
    assign bus.alu_src_b    = ctrl_q.alu_src_b;
    assign bus.alu_function = ctrl_q.alu_function;
    assign bus.state        = state_q;

    always_comb begin
        case (bus.opcode)
            OP_STORE:  bus.imm_src = 3'b001;
            OP_BRANCH: bus.imm_src = 3'b010;
            OP_LUI:    bus.imm_src = 3'b011;
            OP_JAL:    bus.imm_src = 3'b100;
            default:   bus.imm_src = 3'b000;
        endcase
    end
endmodule

// File: tb/tb_multi_cycle_controller.sv
// Directed bench for multi_cycle_controller: per-cycle expected output vectors queued per instruction,
// popped and compared at each cycle of the instruction.
module tb_multi_cycle_controller;
    localparam int W = 22;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADR = 4'd2, S_MEM_READ = 4'd3;
    localparam logic [3:0] S_MEM_WB = 4'd4, S_MEM_WRITE = 4'd5, S_EXEC_R = 4'd6, S_EXEC_I = 4'd7;
    localparam logic [3:0] S_ALU_WB = 4'd8, S_BRANCH = 4'd9, S_JALR_ADR = 4'd10, S_JUMP = 4'd11;
    localparam logic [3:0] S_LUI = 4'd12;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;
    logic [W-1:0] exp_q[$];

    multi_cycle_controller_if bus();

    multi_cycle_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {state, pc_write, adr_src, mem_write, ir_write, reg_write, result_src, alu_src_a, alu_src_b, alu_function, imm_src, illegal}
    function automatic logic [W-1:0] ev(input logic [3:0] st, input logic pcw, input logic adr,
                                        input logic mw, input logic irw, input logic rw,
                                        input logic [1:0] rs, input logic [1:0] a, input logic [1:0] b,
                                        input logic [2:0] fn, input logic [2:0] imm, input logic ill);
        return {st, pcw, adr, mw, irw, rw, rs, a, b, fn, imm, ill};
    endfunction

    function automatic logic [W-1:0] obs_vec();
        return {bus.state, bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.reg_write,
                bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.alu_function, bus.imm_src, bus.illegal};
    endfunction

    task automatic check(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // expected-vector pushers for recurring states
    task automatic push_reset(input logic [2:0] imm);
        exp_q.push_back(ev(S_FETCH, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, imm, 0));
    endtask

    task automatic push_fetch_decode(input logic [2:0] imm, input logic ill);
        exp_q.push_back(ev(S_FETCH,  1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, imm, 0));
        exp_q.push_back(ev(S_DECODE, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, imm, ill));
    endtask

    task automatic push_alu_wb(input logic [2:0] imm);
        exp_q.push_back(ev(S_ALU_WB, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, imm, 0));
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7, input logic z);
        bus.opcode = op;
        bus.f3     = f3;
        bus.f7     = f7;
        bus.zero   = z;
    endtask

    // driver: called at a negedge in FETCH; runs exactly as many cycles as were queued
    task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input logic z);
        int n;
        logic [W-1:0] e;
        drive(op, f3, f7, z);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            #1;
            e = exp_q.pop_front();
            check($sformatf("%s_c%0d", tag, i), obs_vec(), e);
            @(negedge clk);
        end
    endtask

    logic [2:0] br_f3  [8];
    logic       br_z   [8];
    logic       br_tk  [8];
    logic [2:0] br_fn  [8];

    initial begin
        logic [W-1:0] e;
        tests_run    = 0;
        tests_failed = 0;
        reset = 1'b0;
        drive(7'b0110011, 3'b000, 7'h00, 1'b0);

        // reset held low for 3 cycles: strobes off, FETCH selects visible
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            push_reset(3'b000);
            e = exp_q.pop_front();
            check($sformatf("reset_c%0d", i), obs_vec(), e);
        end
        @(negedge clk);
        reset = 1'b1;

        // add / sub
        push_fetch_decode(3'b000, 0);
        exp_q.push_back(ev(S_EXEC_R, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b000, 0));
        push_alu_wb(3'b000);
        run_instr("add", 7'b0110011, 3'b000, 7'h00, 1'b0);

        push_fetch_decode(3'b000, 0);
        exp_q.push_back(ev(S_EXEC_R, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000, 0));
        push_alu_wb(3'b000);
        run_instr("sub", 7'b0110011, 3'b000, 7'h20, 1'b0);

        push_fetch_decode(3'b000, 0);
        exp_q.push_back(ev(S_EXEC_R, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b110, 3'b000, 0));
        push_alu_wb(3'b000);
        run_instr("sltu", 7'b0110011, 3'b011, 7'h00, 1'b0);

        // I-ALU: ori, and addi with imm bit 30 set must stay add
        push_fetch_decode(3'b000, 0);
        exp_q.push_back(ev(S_EXEC_I, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b011, 3'b000, 0));
        push_alu_wb(3'b000);
        run_instr("ori", 7'b0010011, 3'b110, 7'h00, 1'b0);

        push_fetch_decode(3'b000, 0);
        exp_q.push_back(ev(S_EXEC_I, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0));
        push_alu_wb(3'b000);
        run_instr("addi", 7'b0010011, 3'b000, 7'h20, 1'b0);

        // lw: 5 cycles
        push_fetch_decode(3'b000, 0);
        exp_q.push_back(ev(S_MEM_ADR,  0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0));
        exp_q.push_back(ev(S_MEM_READ, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
        exp_q.push_back(ev(S_MEM_WB,   0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 0));
        run_instr("lw", 7'b0000011, 3'b010, 7'h00, 1'b0);

        // sw: 4 cycles, mem_write only in MEM_WRITE
        push_fetch_decode(3'b001, 0);
        exp_q.push_back(ev(S_MEM_ADR,   0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001, 0));
        exp_q.push_back(ev(S_MEM_WRITE, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 0));
        run_instr("sw", 7'b0100011, 3'b010, 7'h00, 1'b0);

        // branches: beq, bne, blt, bge with zero 0 and 1
        br_f3 = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b100, 3'b100, 3'b101, 3'b101};
        br_z  = '{1'b0,   1'b1,   1'b0,   1'b1,   1'b0,   1'b1,   1'b0,   1'b1};
        br_tk = '{1'b0,   1'b1,   1'b1,   1'b0,   1'b1,   1'b0,   1'b0,   1'b1};
        br_fn = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b101, 3'b101, 3'b101, 3'b101};
        for (int k = 0; k < 8; k++) begin
            push_fetch_decode(3'b010, 0);
            exp_q.push_back(ev(S_BRANCH, br_tk[k], 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, br_fn[k], 3'b010, 0));
            run_instr($sformatf("br_f%0d_z%0d", br_f3[k], br_z[k]), 7'b1100011, br_f3[k], 7'h00, br_z[k]);
        end

        // jal: 4 cycles
        push_fetch_decode(3'b100, 0);
        exp_q.push_back(ev(S_JUMP, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b100, 0));
        push_alu_wb(3'b100);
        run_instr("jal", 7'b1101111, 3'b000, 7'h00, 1'b0);

        // jalr: 5 cycles through JALR_ADR
        push_fetch_decode(3'b000, 0);
        exp_q.push_back(ev(S_JALR_ADR, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0));
        exp_q.push_back(ev(S_JUMP,     1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b000, 0));
        push_alu_wb(3'b000);
        run_instr("jalr", 7'b1100111, 3'b000, 7'h00, 1'b0);

        // lui: 3 cycles
        push_fetch_decode(3'b011, 0);
        exp_q.push_back(ev(S_LUI, 0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 3'b000, 3'b011, 0));
        run_instr("lui", 7'b0110111, 3'b000, 7'h00, 1'b0);

        // illegal encodings: 2 cycles, pulse only in DECODE, no writes
        push_fetch_decode(3'b000, 1);
        run_instr("ill_fence", 7'b0001111, 3'b000, 7'h00, 1'b0);
        push_fetch_decode(3'b001, 1);
        run_instr("ill_sw_f3", 7'b0100011, 3'b000, 7'h00, 1'b0);
        push_fetch_decode(3'b000, 1);
        run_instr("ill_r_f7", 7'b0110011, 3'b100, 7'h20, 1'b0);
        push_fetch_decode(3'b000, 1);
        run_instr("ill_r_f3", 7'b0110011, 3'b001, 7'h00, 1'b0);
        push_fetch_decode(3'b010, 1);
        run_instr("ill_br_f3", 7'b1100011, 3'b010, 7'h00, 1'b1);
        push_fetch_decode(3'b000, 1);
        run_instr("ill_jalr_f3", 7'b1100111, 3'b001, 7'h00, 1'b0);

        // reset asserted while in MEM_WRITE: mem_write must drop without a clock edge
        drive(7'b0100011, 3'b010, 7'h00, 1'b0);
        push_fetch_decode(3'b001, 0);
        exp_q.push_back(ev(S_MEM_ADR,   0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001, 0));
        exp_q.push_back(ev(S_MEM_WRITE, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 0));
        for (int i = 0; i < 4; i++) begin
            #1;
            e = exp_q.pop_front();
            check($sformatf("abort_c%0d", i), obs_vec(), e);
            if (i < 3) @(negedge clk);
        end
        #1;
        reset = 1'b0;
        #1;
        push_reset(3'b001);
        e = exp_q.pop_front();
        check("abort_async", obs_vec(), e);
        @(negedge clk);
        #1;
        push_reset(3'b001);
        e = exp_q.pop_front();
        check("abort_hold", obs_vec(), e);
        @(negedge clk);
        reset = 1'b1;

        // restart from FETCH after abort
        push_fetch_decode(3'b011, 0);
        exp_q.push_back(ev(S_LUI, 0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 3'b000, 3'b011, 0));
        run_instr("lui_restart", 7'b0110111, 3'b000, 7'h00, 1'b0);

        tests_run++;
        assert (exp_q.size() == 0) else begin
            tests_failed++;
            $error("FAIL queue_empty observed=%0d expected=0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/multi_cycle_controller.md
# multi_cycle_controller

Finite-state controller for the multi-cycle RV32I core. It consumes the decode fields and ALU flag that the datapath exports, and drives every mux select and write enable one state per clock. It replaces the single-cycle combinational decoder. It sits beside the multi-cycle datapath, which holds PC, old_pc, IR, data, A, B and alu_out registers and a single unified memory.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low; low forces state FETCH immediately.
- opcode  in  7  IR[6:0].
- f3  in  3  IR[14:12].
- f7  in  7  IR[31:25]; only bit 5 (IR[30]) is decoded.
- zero  in  1  ALU result == 0, combinational from the current ALU operation.
- pc_write  out  1  load PC from the result mux.
- adr_src  out  1  memory address: 0 = PC, 1 = result mux.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  load IR and old_pc.
- reg_write  out  1  register-file write strobe.
- result_src  out  2  result mux: 00 = alu_out reg, 01 = data reg, 10 = ALU direct, 11 = immediate.
- alu_src_a  out  2  ALU A operand: 00 = PC, 01 = old_pc, 10 = A reg.
- alu_src_b  out  2  ALU B operand: 00 = B reg, 01 = immediate, 10 = constant 4.
- alu_function  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sltu.
- imm_src  out  3  000 I, 001 S, 010 B, 011 U, 100 J.
- illegal  out  1  one-cycle pulse in DECODE for an unsupported encoding.

## Operation
- Supported instructions:
  - R-type (0110011): add, sub, and, or, xor, slt, sltu.
  - I-ALU (0010011): addi, andi, ori, xori, slti, sltiu.
  - lw (0000011, f3 = 010), sw (0100011, f3 = 010).
  - Branch (1100011): beq, bne, blt, bge.
  - jal (1101111), jalr (1100111, f3 = 000), lui (0110111).
- Outputs not listed for a state are 0 / 000; imm_src is decoded from opcode in every state.
- State actions and transitions:
  - FETCH: adr_src 0, ir_write 1, A = PC, B = 4, add, result_src 10, pc_write 1. Next: DECODE.
  - DECODE: A = old_pc, B = imm, add (branch/jal target into alu_out). Next by opcode:
    - lw/sw -> MEM_ADR
    - R -> EXEC_R; I-ALU -> EXEC_I
    - branch -> BRANCH; jal -> JUMP; jalr -> JALR_ADR; lui -> LUI
    - anything else -> FETCH with illegal = 1
  - MEM_ADR: A = A reg, B = imm, add. Next: MEM_READ for lw, MEM_WRITE for sw.
  - MEM_READ: adr_src 1, result_src 00. Next: MEM_WB.
  - MEM_WB: result_src 01, reg_write 1. Next: FETCH.
  - MEM_WRITE: adr_src 1, result_src 00, mem_write 1. Next: FETCH.
  - EXEC_R: A reg op B reg. Function from f3: 000 add / sub (sub if f7[5]), 111 and, 110 or, 100 xor, 010 slt, 011 sltu. Next: ALU_WB.
  - EXEC_I: A reg op imm, same f3 map, never sub. Next: ALU_WB.
  - ALU_WB: result_src 00, reg_write 1. Next: FETCH.
  - BRANCH: A reg vs B reg, result_src 00. Function: beq/bne use sub; blt/bge use slt. pc_write = taken. Next: FETCH.
    - beq: taken if zero. bne: taken if !zero.
    - blt: taken if !zero. bge: taken if zero.
  - JALR_ADR: A reg + imm into alu_out. Next: JUMP.
  - JUMP: result_src 00, pc_write 1, A = old_pc, B = 4, add. Next: ALU_WB (writes old_pc + 4 to rd).
  - LUI: result_src 11, reg_write 1. Next: FETCH.
- Illegal encodings: unknown opcode, unknown f3 in any class, R-type f7[5] with f3 != 000, lw/sw f3 != 010, branch f3 not in {000, 001, 100, 101}, jalr f3 != 000.
  - Each pulses illegal in DECODE and returns to FETCH with no architectural write.
- pc_write in BRANCH is Mealy (depends on zero). All other outputs are Moore (state and IR fields only).

## Timing
- Cycles per instruction:
  - lw 5; sw 4; R and I-ALU 4; jal 4; jalr 5; branch 3; lui 3; illegal 2.
- While reset is low: state = FETCH, and pc_write, ir_write, mem_write, reg_write and illegal are all forced 0. Other outputs show FETCH values.
- First FETCH actions occur on the first rising clk after reset deasserts.
- Reset asserted mid-instruction aborts it: no write strobe may be high in the reset-low period, and execution restarts at FETCH.
- Exactly one state transition per clock; no wait states and no memory handshake (memory is single-cycle).

## Test plan
- Reset low for 3 cycles, then released:
  - During reset: all strobes 0, state FETCH.
  - First edge after release: pc_write = ir_write = 1.
  - Pull reset low while in MEM_WRITE: mem_write drops to 0 asynchronously.
- add then sub (opcode 0110011, f3 000, f7 0x00 / 0x20): sequence FETCH, DECODE, EXEC_R (function 000, then 001), ALU_WB with reg_write 1.
- lw (0000011, f3 010): exactly 5 states. adr_src 1 in MEM_READ; result_src 01 and reg_write in MEM_WB. sw: mem_write high for exactly 1 cycle.
- Branches, each with zero = 0 and zero = 1:
  - beq zero = 1: pc_write 1. bne zero = 1: pc_write 0.
  - blt zero = 0: pc_write 1. bge zero = 0: pc_write 0.
- jal then jalr: pc_write in JUMP, then reg_write in ALU_WB. jalr passes through JALR_ADR (A reg + imm). Total 4 and 5 cycles.
- Opcode 0001111 and sw with f3 000: illegal pulses 1 cycle in DECODE, next state FETCH, zero writes.
